// File: rtl/spi_cmd_master.sv
// SPI initiator: serialises 10-bit RAM commands MSB-first under SS_n and, for
// read-data commands, captures the returned byte after a fixed turnaround.
module spi_cmd_master #(
    parameter int DATA_WIDTH = 8,
    parameter int TURNAROUND = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH+1:0] cmd_data,
    output logic                  ss_n,
    output logic                  mosi,
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic [2:0]            dbg_state
);
    localparam int CMD_W     = DATA_WIDTH + 2;
    localparam int CNT_MAX_A = (CMD_W - 1 > TURNAROUND - 1) ? CMD_W - 1 : TURNAROUND - 1;
    localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES - 1) ? CNT_MAX_A : GAP_CYCLES - 1;
    localparam int CW        = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_TURN    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_STOP    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CW-1:0]         r_cnt;
    logic [CMD_W-1:0]      r_shift;
    logic                  r_is_read;
    logic [DATA_WIDTH-2:0] r_rx;
    logic                  r_ss_n;
    logic                  r_mosi;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_accept;
    logic                  w_cnt_zero;
    logic                  w_mosi_next;
    logic [DATA_WIDTH-1:0] w_rx_full;

    // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and cmd_data is ignored otherwise.
    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign dbg_state  = r_state;
    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_rx_full  = {r_rx, miso};

    assign ss_n     = r_ss_n;
    assign mosi     = r_mosi;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mosi_next  = 1'b0;
        case (r_state)
            ST_IDLE:    if (cmd_valid) w_next_state = ST_SHIFT;
            ST_SHIFT:   if (w_cnt_zero) w_next_state = r_is_read ? ST_TURN : ST_STOP;
            ST_TURN:    if (w_cnt_zero) w_next_state = ST_CAPTURE;
            ST_CAPTURE: if (w_cnt_zero) w_next_state = ST_STOP;
            ST_STOP:    if (w_cnt_zero) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
        // Outputs are registered, so the bit presented next cycle is chosen here.
        if (w_next_state == ST_SHIFT) begin
            w_mosi_next = (r_state == ST_IDLE) ? cmd_data[CMD_W-1] : r_shift[CMD_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_is_read  <= 1'b0;
            r_rx       <= '0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_ss_n     <= (w_next_state == ST_IDLE) || (w_next_state == ST_STOP);
            r_mosi     <= w_mosi_next;
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= {cmd_data[CMD_W-2:0], 1'b0};
                        r_is_read <= (cmd_data[CMD_W-1:CMD_W-2] == 2'b11);
                        r_cnt     <= CW'(CMD_W - 1);
                    end
                end
                ST_SHIFT: begin
                    r_shift <= {r_shift[CMD_W-2:0], 1'b0};
                    if (w_cnt_zero) begin
                        r_cnt <= r_is_read ? CW'(TURNAROUND - 1) : CW'(GAP_CYCLES - 1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_TURN: begin
                    if (w_cnt_zero) begin
                        r_cnt <= CW'(DATA_WIDTH - 1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_CAPTURE: begin
                    r_rx <= w_rx_full[DATA_WIDTH-2:0];
                    if (w_cnt_zero) begin
                        r_rd_data  <= w_rx_full;
                        r_rd_valid <= 1'b1;
                        r_cnt      <= CW'(GAP_CYCLES - 1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_STOP: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: two builds (default and TURNAROUND=1/GAP_CYCLES=3)
// checked cycle by cycle against frame-level expectations.
module tb_spi_cmd_master;
    localparam int T0 = 2, G0 = 1;
    localparam int T1 = 1, G1 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid [2];
    logic [9:0] cmd_data  [2];
    logic       miso      [2];
    logic       cmd_ready [2];
    logic       ss_n      [2];
    logic       mosi      [2];
    logic [7:0] rd_data   [2];
    logic       rd_valid  [2];
    logic       busy      [2];
    logic [2:0] dbg_state [2];

    int         n_cmp = 0;
    int         n_err = 0;
    int         cur_sel = 0;
    logic [7:0] exp_rd [2];
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    spi_cmd_master #(.DATA_WIDTH(8), .TURNAROUND(T0), .GAP_CYCLES(G0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_data(cmd_data[0]), .ss_n(ss_n[0]), .mosi(mosi[0]), .miso(miso[0]),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0]), .dbg_state(dbg_state[0])
    );

    spi_cmd_master #(.DATA_WIDTH(8), .TURNAROUND(T1), .GAP_CYCLES(G1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_data(cmd_data[1]), .ss_n(ss_n[1]), .mosi(mosi[1]), .miso(miso[1]),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1]), .dbg_state(dbg_state[1])
    );

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d k=%0d: observed %0h expected %0h", tag, cur_sel, k, obs, exp);
        end
    endtask

    // One command on one build. Entered and left at a negedge; with hold set,
    // cmd_valid stays high and the following command is presented during the frame.
    task automatic run_frame(input int sel, input logic [9:0] cmd, input logic [9:0] next_cmd,
                             input bit hold, input logic [7:0] rx);
        int         t, g, len, n;
        bit         rd;
        logic [3:0] e;
        cur_sel = sel;
        t   = (sel == 0) ? T0 : T1;
        g   = (sel == 0) ? G0 : G1;
        rd  = (cmd[9:8] == 2'b11);
        len = rd ? 10 + t + 8 : 10;
        n   = len + g + 1;
        exp_q.delete();
        for (int k = 1; k <= n; k++) begin
            exp_q.push_back({(k > len) ? 1'b1 : 1'b0,
                             (k <= 10) ? cmd[10-k] : 1'b0,
                             (rd && k == len + 1) ? 1'b1 : 1'b0,
                             (k == n) ? 1'b1 : 1'b0});
        end
        cmd_valid[sel] = 1'b1;
        cmd_data[sel]  = cmd;
        check("accept_ready", 0, 32'(cmd_ready[sel]), 32'd1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    cmd_data[sel] = next_cmd;
                end else begin
                    cmd_valid[sel] = 1'b0;
                    cmd_data[sel]  = 10'($urandom);
                end
            end
            if (rd && k >= 11 + t && k <= 18 + t) miso[sel] = rx[7-(k-11-t)];
            else miso[sel] = 1'($urandom);
            if (rd && k == len + 1) exp_rd[sel] = rx;
            e = exp_q.pop_front();
            check("ss_n", k, 32'(ss_n[sel]), 32'(e[3]));
            check("mosi", k, 32'(mosi[sel]), 32'(e[2]));
            check("rd_valid", k, 32'(rd_valid[sel]), 32'(e[1]));
            check("cmd_ready", k, 32'(cmd_ready[sel]), 32'(e[0]));
            check("busy", k, 32'(busy[sel]), 32'(!e[0]));
            check("rd_data", k, 32'(rd_data[sel]), 32'(exp_rd[sel]));
        end
    endtask

    task automatic check_reset_state(input int sel);
        cur_sel = sel;
        check("rst_ss_n", 0, 32'(ss_n[sel]), 32'd1);
        check("rst_mosi", 0, 32'(mosi[sel]), 32'd0);
        check("rst_rd_data", 0, 32'(rd_data[sel]), 32'd0);
        check("rst_rd_valid", 0, 32'(rd_valid[sel]), 32'd0);
        check("rst_cmd_ready", 0, 32'(cmd_ready[sel]), 32'd1);
        check("rst_busy", 0, 32'(busy[sel]), 32'd0);
    endtask

    initial begin
        logic [9:0] c1, c2, c3;
        logic [7:0] rx;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            cmd_valid[s] = 1'b0;
            cmd_data[s]  = '0;
            miso[s]      = 1'b0;
            exp_rd[s]    = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed frames on the default build.
        run_frame(0, 10'h0A5, 10'h0, 1'b0, 8'h00);
        run_frame(0, 10'h13C, 10'h0, 1'b0, 8'h00);
        run_frame(0, 10'h2A5, 10'h0, 1'b0, 8'h00);
        run_frame(0, 10'h300, 10'h0, 1'b0, 8'h3C);
        run_frame(0, 10'h3FF, 10'h0, 1'b0, 8'hA6);

        // cmd_valid held high across three queued commands.
        c1 = 10'($urandom);
        c2 = 10'($urandom);
        c3 = {2'b11, 8'($urandom)};
        rx = 8'($urandom) | 8'h01;
        run_frame(0, c1, c2, 1'b1, 8'($urandom));
        run_frame(0, c2, c3, 1'b1, 8'($urandom));
        run_frame(0, c3, 10'h0, 1'b0, rx);

        // Reset during CAPTURE: abandon the frame and clear rd_data.
        cur_sel = 0;
        cmd_valid[0] = 1'b1;
        cmd_data[0]  = 10'h3C5;
        check("mid_accept_ready", 0, 32'(cmd_ready[0]), 32'd1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid[0] = 1'b0;
            miso[0] = 1'($urandom);
        end
        check("pre_rst_ss_n", 17, 32'(ss_n[0]), 32'd0);
        check("pre_rst_busy", 17, 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        check_reset_state(0);
        check_reset_state(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_hold_rd_valid", k, 32'(rd_valid[0]), 32'd0);
            check("rst_hold_ss_n", k, 32'(ss_n[0]), 32'd1);
        end
        rst_n = 1'b1;
        run_frame(0, 10'h3C5, 10'h0, 1'b0, 8'h5B);

        // Random commands on the default build.
        for (int i = 0; i < 10; i++) begin
            c1 = 10'($urandom);
            if (i % 3 == 0) c1[9:8] = 2'b11;
            run_frame(0, c1, 10'h0, 1'b0, 8'($urandom));
        end

        // TURNAROUND=1, GAP_CYCLES=3 build.
        run_frame(1, 10'h300, 10'h0, 1'b0, 8'hC3);
        run_frame(1, 10'h0A5, 10'h0, 1'b0, 8'h00);
        c1 = 10'($urandom);
        c2 = {2'b11, 8'($urandom)};
        run_frame(1, c1, c2, 1'b1, 8'($urandom));
        run_frame(1, c2, 10'h0, 1'b0, 8'($urandom));
        for (int i = 0; i < 6; i++) begin
            c1 = 10'($urandom);
            if (i % 2 == 0) c1[9:8] = 2'b11;
            run_frame(1, c1, 10'h0, 1'b0, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
